// File: rtl/debounce_pkg.sv
// Shared widths, helpers and default timing constants for the debounce bank.
package debounce_pkg;

    localparam int unsigned DEF_TICK_DIV     = 1000;
    localparam int unsigned DEF_STABLE_TICKS = 16;
    localparam int unsigned DEF_HOLD_TICKS   = 500;
    localparam int unsigned DEF_RPT_TICKS    = 100;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stability counter, debounced level,
// edge pulses and optional press-and-hold auto-repeat.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter bit          ACTIVE_LOW   = 1'b0,
    parameter bit          REPEAT_EN    = 1'b0,
    parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int unsigned RPT_TICKS    = DEF_RPT_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic btn_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int unsigned SW        = cnt_width(STABLE_TICKS);
    localparam int unsigned HW        = cnt_width(max2(HOLD_TICKS, RPT_TICKS));
    localparam bit          USE_PHASE = (RPT_TICKS > HOLD_TICKS);
    localparam logic [SW-1:0] S_LAST   = SW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] R_LAST   = HW'(RPT_TICKS - 1);
    // Preloading HOLD-RPT makes every later period RPT ticks long; a phase flag
    // does the same job when RPT exceeds HOLD and the preload would go negative.
    localparam logic [HW-1:0] H_RELOAD = USE_PHASE ? HW'(0) : HW'(HOLD_TICKS - RPT_TICKS);

    logic          s0_q, s1_q;
    logic          state_q, state_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          rep_q, rep_d;
    logic          phase_q, phase_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          lvl;
    logic          flip;

    assign lvl = ACTIVE_LOW ? ~s1_q : s1_q;

    // Stability counting, edge pulses and repeat scheduling.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        rep_d   = 1'b0;
        hcnt_d  = hcnt_q;
        phase_d = phase_q;
        flip    = 1'b0;

        if (lvl == state_q) begin
            scnt_d = '0;
        end else if (tick_i) begin
            if (scnt_q == S_LAST) begin
                flip    = 1'b1;
                state_d = lvl;
                scnt_d  = '0;
                press_d = lvl;
                rel_d   = ~lvl;
            end else begin
                scnt_d = scnt_q + SW'(1);
            end
        end

        if (!REPEAT_EN || !state_q || press_q || flip) begin
            hcnt_d  = '0;
            phase_d = 1'b0;
        end else if (tick_i) begin
            if (hcnt_q == (phase_q ? R_LAST : H_LAST)) begin
                rep_d   = 1'b1;
                hcnt_d  = H_RELOAD;
                phase_d = USE_PHASE;
            end else begin
                hcnt_d = hcnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q    <= ACTIVE_LOW;
            s1_q    <= ACTIVE_LOW;
            state_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rep_q   <= 1'b0;
            phase_q <= 1'b0;
            scnt_q  <= '0;
            hcnt_q  <= '0;
        end else begin
            s0_q    <= btn_i;
            s1_q    <= s0_q;
            state_q <= state_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rep_q   <= rep_d;
            phase_q <= phase_d;
            scnt_q  <= scnt_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign repeat_o  = rep_q;

endmodule

// File: rtl/debounce_bank.sv
// N-channel button debouncer with a shared tick prescaler.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N            = 4,
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter bit          ACTIVE_LOW   = 1'b0,
    parameter bit          REPEAT_EN    = 1'b0,
    parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int unsigned RPT_TICKS    = DEF_RPT_TICKS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_state,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_repeat,
    output logic         any_press
);

    localparam int unsigned PW = cnt_width(TICK_DIV - 1);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          tick_c;

    // Shared prescaler: one tick every TICK_DIV cycles.
    assign tick_c = (pcnt_q == P_LAST);
    assign pcnt_d = tick_c ? '0 : pcnt_q + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_chan
        debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .REPEAT_EN    (REPEAT_EN),
            .HOLD_TICKS   (HOLD_TICKS),
            .RPT_TICKS    (RPT_TICKS)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick_i    (tick_c),
            .btn_i     (btn_in[g]),
            .state_o   (btn_state[g]),
            .press_o   (btn_press[g]),
            .release_o (btn_release[g]),
            .repeat_o  (btn_repeat[g])
        );
    end

    assign any_press = |btn_press;

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: three instances (plain, auto-repeat,
// active-low) run against a tick-counting reference model.
module tb_debounce_bank;

    localparam int unsigned TD   = 4;
    localparam int unsigned ST   = 3;
    localparam int unsigned HOLD = 8;
    localparam int unsigned RPT  = 2;
    localparam int unsigned P_AL  [3] = '{0, 0, 1};
    localparam int unsigned P_REP [3] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn     [3];
    logic [3:0] o_state [3];
    logic [3:0] o_press [3];
    logic [3:0] o_rel   [3];
    logic [3:0] o_rep   [3];
    logic       o_any   [3];

    // Reference model state
    logic [3:0] m_s0 [3], m_s1 [3];
    logic [3:0] m_state [3], m_press [3], m_rel [3], m_rep [3];
    int         m_cyc [3];
    int         m_run [3][4];
    int         m_held [3][4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    debounce_bank #(.N(4), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(1'b0),
                    .REPEAT_EN(1'b0), .HOLD_TICKS(HOLD), .RPT_TICKS(RPT)) u_dut0 (
        .clk(clk), .rst(rst), .btn_in(btn[0]), .btn_state(o_state[0]), .btn_press(o_press[0]),
        .btn_release(o_rel[0]), .btn_repeat(o_rep[0]), .any_press(o_any[0]));

    debounce_bank #(.N(4), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(1'b0),
                    .REPEAT_EN(1'b1), .HOLD_TICKS(HOLD), .RPT_TICKS(RPT)) u_dut1 (
        .clk(clk), .rst(rst), .btn_in(btn[1]), .btn_state(o_state[1]), .btn_press(o_press[1]),
        .btn_release(o_rel[1]), .btn_repeat(o_rep[1]), .any_press(o_any[1]));

    debounce_bank #(.N(4), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(1'b1),
                    .REPEAT_EN(1'b0), .HOLD_TICKS(HOLD), .RPT_TICKS(RPT)) u_dut2 (
        .clk(clk), .rst(rst), .btn_in(btn[2]), .btn_state(o_state[2]), .btn_press(o_press[2]),
        .btn_release(o_rel[2]), .btn_repeat(o_rep[2]), .any_press(o_any[2]));

    // Model: a level must differ from the debounced state for ST consecutive
    // ticks; repeats fire when ticks-held hits HOLD, then every RPT ticks.
    function automatic void model_edge();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_s0[k] = (P_AL[k] != 0) ? 4'hF : 4'h0;
                m_s1[k] = m_s0[k];
                m_cyc[k] = 0;
                m_state[k] = '0; m_press[k] = '0; m_rel[k] = '0; m_rep[k] = '0;
                for (int c = 0; c < 4; c++) begin
                    m_run[k][c] = 0;
                    m_held[k][c] = 0;
                end
            end else begin
                bit tick;
                tick = ((m_cyc[k] % TD) == (TD - 1));
                m_cyc[k]++;
                for (int c = 0; c < 4; c++) begin
                    bit lvl, was_state, was_press, flipped;
                    lvl       = m_s1[k][c] ^ (P_AL[k] != 0);
                    was_state = m_state[k][c];
                    was_press = m_press[k][c];
                    flipped   = 1'b0;
                    m_press[k][c] = 1'b0; m_rel[k][c] = 1'b0; m_rep[k][c] = 1'b0;
                    if (lvl == was_state) begin
                        m_run[k][c] = 0;
                    end else if (tick) begin
                        m_run[k][c]++;
                        if (m_run[k][c] == ST) begin
                            flipped = 1'b1;
                            m_state[k][c] = lvl;
                            m_run[k][c] = 0;
                            m_press[k][c] = lvl;
                            m_rel[k][c] = !lvl;
                        end
                    end
                    if (!was_state || was_press || flipped) begin
                        m_held[k][c] = 0;
                    end else if (tick) begin
                        m_held[k][c]++;
                        if (P_REP[k] != 0 && (m_held[k][c] == HOLD ||
                            (m_held[k][c] > HOLD && ((m_held[k][c] - HOLD) % RPT) == 0)))
                            m_rep[k][c] = 1'b1;
                    end
                end
                m_s1[k] = m_s0[k];
                m_s0[k] = btn[k];
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int first = -1;
        int npress = 0;
        logic [3:0] pval = '0;
        btn[0] = 4'hF; btn[1] = 4'hF; btn[2] = 4'hF;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if ({o_state[k], o_press[k], o_rel[k], o_rep[k], o_any[k]} !== 17'h0) begin
                    n_bad++;
                    $display("FAIL reset_zero inst%0d: got st=%h pr=%h rl=%h rp=%h any=%b, want all 0",
                             k, o_state[k], o_press[k], o_rel[k], o_rep[k], o_any[k]);
                end
            end
        end
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if ({o_state[k], o_press[k], o_rel[k], o_rep[k], o_any[k]} !==
                    {m_state[k], m_press[k], m_rel[k], m_rep[k], |m_press[k]}) begin
                    n_bad++;
                    $display("FAIL model_reset inst%0d @%0t: dut st=%h pr=%h rl=%h rp=%h any=%b, want st=%h pr=%h rl=%h rp=%h",
                             k, $time, o_state[k], o_press[k], o_rel[k], o_rep[k], o_any[k],
                             m_state[k], m_press[k], m_rel[k], m_rep[k]);
                end
            end
            if (o_press[0] !== 4'h0) begin
                npress++;
                if (first < 0) begin first = c; pval = o_press[0]; end
            end
        end
        n_cmp++;
        if (npress != 1 || pval !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_exit_press: got %0d pulse cycles value %h, want 1 cycle value f", npress, pval);
        end
        n_cmp++;
        if (first < 3 || first > 14) begin
            n_bad++;
            $display("FAIL reset_exit_latency: got %0d cycles, want 3..14", first);
        end
        n_cmp++;
        if (o_state[0] !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_exit_state: got %h, want f", o_state[0]);
        end
    endtask

    task automatic test_bounce();
        int early = 0;
        int first = -1;
        int other = 0;
        btn[0] = 4'h0; btn[1] = 4'h0; btn[2] = 4'hF;
        do_reset(2);
        for (int i = 0; i < 60; i++) begin
            if (i % 5 == 0) btn[0][0] = ~btn[0][0];
            step();
            if ((o_press[0] | o_rel[0]) !== 4'h0) early++;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if ({o_state[k], o_press[k], o_rel[k], o_rep[k], o_any[k]} !==
                    {m_state[k], m_press[k], m_rel[k], m_rep[k], |m_press[k]}) begin
                    n_bad++;
                    $display("FAIL model_bounce inst%0d @%0t: dut st=%h pr=%h rl=%h rp=%h any=%b, want st=%h pr=%h rl=%h rp=%h",
                             k, $time, o_state[k], o_press[k], o_rel[k], o_rep[k], o_any[k],
                             m_state[k], m_press[k], m_rel[k], m_rep[k]);
                end
            end
        end
        n_cmp++;
        if (early != 0) begin
            n_bad++;
            $display("FAIL bounce_reject: got %0d pulse cycles while bouncing, want 0", early);
        end
        btn[0] = 4'h1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (o_press[0][0] === 1'b1 && first < 0) first = c;
            if (o_press[0][3:1] !== 3'b0) other++;
        end
        n_cmp++;
        if (first < 3 || first > 14 || other != 0) begin
            n_bad++;
            $display("FAIL bounce_final_press: got latency %0d others %0d, want 3..14 and 0", first, other);
        end
    endtask

    task automatic test_release();
        int relc = -1;
        int presses = 0;
        btn[0] = 4'h3;
        repeat (20) step();
        btn[0] = 4'h1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (o_press[0] !== 4'h0) presses++;
            n_cmp++;
            if ({o_state[0], o_press[0], o_rel[0], o_rep[0], o_any[0]} !==
                {m_state[0], m_press[0], m_rel[0], m_rep[0], |m_press[0]}) begin
                n_bad++;
                $display("FAIL model_release @%0t: dut st=%h pr=%h rl=%h, want st=%h pr=%h rl=%h",
                         $time, o_state[0], o_press[0], o_rel[0], m_state[0], m_press[0], m_rel[0]);
            end
            if (relc < 0 && o_rel[0] !== 4'h0) begin
                relc = c;
                n_cmp++;
                if (o_rel[0] !== 4'h2 || o_state[0] !== 4'h1) begin
                    n_bad++;
                    $display("FAIL release_same_cycle: got rel=%h state=%h, want rel=2 state=1", o_rel[0], o_state[0]);
                end
                step();
                n_cmp++;
                if (o_rel[0] !== 4'h0) begin
                    n_bad++;
                    $display("FAIL release_one_cycle: got rel=%h next cycle, want 0", o_rel[0]);
                end
            end
        end
        n_cmp++;
        if (relc < 0 || presses != 0) begin
            n_bad++;
            $display("FAIL release_seen: got release cycle %0d presses %0d, want >0 and 0", relc, presses);
        end
    endtask

    task automatic test_repeat();
        int pc = -1;
        int rcount = 0;
        int last = 0;
        int badgap = 0;
        int firstr = -1;
        int after = 0;
        bit rel_seen = 1'b0;
        btn[0] = 4'h0; btn[1] = 4'h0; btn[2] = 4'hF;
        do_reset(2);
        btn[1] = 4'h4;
        for (int c = 1; c <= 20 && pc < 0; c++) begin
            step();
            if (o_press[1][2] === 1'b1) pc = c;
        end
        for (int d = 1; d <= 64; d++) begin
            step();
            n_cmp++;
            if ({o_state[1], o_press[1], o_rel[1], o_rep[1], o_any[1]} !==
                {m_state[1], m_press[1], m_rel[1], m_rep[1], |m_press[1]}) begin
                n_bad++;
                $display("FAIL model_repeat @%0t: dut st=%h pr=%h rp=%h, want st=%h pr=%h rp=%h",
                         $time, o_state[1], o_press[1], o_rep[1], m_state[1], m_press[1], m_rep[1]);
            end
            if (o_rep[1][2] === 1'b1) begin
                if (firstr < 0) firstr = d;
                else if (d - last != 8) badgap++;
                last = d;
                rcount++;
            end
        end
        n_cmp++;
        if (pc < 0 || firstr != 32) begin
            n_bad++;
            $display("FAIL repeat_first: got press %0d first repeat +%0d, want +32", pc, firstr);
        end
        n_cmp++;
        if (rcount != 5 || badgap != 0) begin
            n_bad++;
            $display("FAIL repeat_period: got %0d pulses %0d bad gaps, want 5 and 0", rcount, badgap);
        end
        btn[1] = 4'h0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (rel_seen && o_rep[1] !== 4'h0) after++;
            if (o_rel[1][2] === 1'b1) begin
                rel_seen = 1'b1;
                if (o_rep[1] !== 4'h0) after++;
            end
        end
        n_cmp++;
        if (!rel_seen || after != 0) begin
            n_bad++;
            $display("FAIL repeat_after_release: got release=%b repeats=%0d, want 1 and 0", rel_seen, after);
        end
    endtask

    task automatic test_active_low();
        int ev = 0;
        int presses = 0;
        btn[2] = 4'hF;
        do_reset(2);
        for (int c = 0; c < 30; c++) begin
            step();
            if ({o_state[2], o_press[2], o_rel[2]} !== 12'h0) ev++;
        end
        n_cmp++;
        if (ev != 0) begin
            n_bad++;
            $display("FAIL active_low_idle: got %0d event cycles, want 0", ev);
        end
        btn[2] = 4'hE;
        for (int c = 0; c < 20; c++) begin
            step();
            if (o_press[2] !== 4'h0) presses++;
            n_cmp++;
            if ({o_state[2], o_press[2], o_rel[2], o_rep[2], o_any[2]} !==
                {m_state[2], m_press[2], m_rel[2], m_rep[2], |m_press[2]}) begin
                n_bad++;
                $display("FAIL model_active_low @%0t: dut st=%h pr=%h, want st=%h pr=%h",
                         $time, o_state[2], o_press[2], m_state[2], m_press[2]);
            end
        end
        n_cmp++;
        if (o_state[2] !== 4'h1 || presses != 1) begin
            n_bad++;
            $display("FAIL active_low_press: got state=%h presses=%0d, want 1 and 1", o_state[2], presses);
        end
    endtask

    task automatic test_simultaneous();
        int pc = -1;
        int npost = 0;
        btn[0] = 4'h0; btn[1] = 4'h0; btn[2] = 4'hF;
        do_reset(2);
        btn[0] = 4'h9;
        for (int c = 1; c <= 20 && pc < 0; c++) begin
            step();
            if (o_press[0] !== 4'h0) begin
                pc = c;
                n_cmp++;
                if (o_press[0] !== 4'h9 || o_any[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL simul_press: got press=%h any=%b, want 9 and 1", o_press[0], o_any[0]);
                end
                step();
                n_cmp++;
                if (o_press[0] !== 4'h0 || o_any[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL simul_one_cycle: got press=%h any=%b, want 0 and 0", o_press[0], o_any[0]);
                end
            end
        end
        n_cmp++;
        if (pc < 0) begin
            n_bad++;
            $display("FAIL simul_seen: got no press within 20 cycles, want one");
        end
        btn[0] = 4'h0;
        repeat (20) step();
        // Abort a count with the input withdrawn during reset.
        btn[0] = 4'h2;
        repeat (7) step();
        rst = 1'b1;
        btn[0] = 4'h0;
        repeat (2) step();
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (o_press[0] !== 4'h0) npost++;
        end
        n_cmp++;
        if (npost != 0) begin
            n_bad++;
            $display("FAIL midreset_abort: got %0d press cycles, want 0", npost);
        end
        // Input held through reset must still wait a full stability window.
        btn[0] = 4'h2;
        repeat (7) step();
        do_reset(2);
        pc = -1;
        for (int c = 1; c <= 20 && pc < 0; c++) begin
            step();
            if (o_press[0] !== 4'h0) pc = c;
        end
        n_cmp++;
        if (pc != 12) begin
            n_bad++;
            $display("FAIL midreset_full_window: got press at %0d, want 12", pc);
        end
    endtask

    task automatic test_random();
        int cnt [3][4];
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++) cnt[k][c] = 1;
        for (int i = 0; i < 900; i++) begin
            for (int k = 0; k < 3; k++) begin
                for (int c = 0; c < 4; c++) begin
                    cnt[k][c]--;
                    if (cnt[k][c] <= 0) begin
                        btn[k][c] = ~btn[k][c];
                        cnt[k][c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6))
                                                                  : int'($urandom_range(10, 70));
                    end
                end
            end
            rst = (i >= 450 && i < 452);
            step();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if ({o_state[k], o_press[k], o_rel[k], o_rep[k], o_any[k]} !==
                    {m_state[k], m_press[k], m_rel[k], m_rep[k], |m_press[k]}) begin
                    n_bad++;
                    $display("FAIL model_random inst%0d @%0t: dut st=%h pr=%h rl=%h rp=%h any=%b, want st=%h pr=%h rl=%h rp=%h",
                             k, $time, o_state[k], o_press[k], o_rel[k], o_rep[k], o_any[k],
                             m_state[k], m_press[k], m_rel[k], m_rep[k]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        btn[0] = 4'h0; btn[1] = 4'h0; btn[2] = 4'hF;
        test_reset();
        test_bounce();
        test_release();
        test_repeat();
        test_active_low();
        test_simultaneous();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
